rf_wb_scheduler: RTL
====================

Name: rf_wb_scheduler

Overview:
- Schedules the single write port of the 32x32 register file (`CLK`, `RegWEn`, `AddrD`, `DataD`) between two writeback requesters:
  - requester 0: the single-cycle ALU/load pipeline.
  - requester 1: a multi-cycle unit (mul/div).
- Holds a per-register scoreboard of destinations with a long-latency write outstanding, and stalls issue on RAW/WAW hazards against them.
- Sits between the execute/writeback stages and the register file; its registered outputs drive the write port directly.

Parameters:
- XLEN, 32, data width of writeback values and of `DataD`.
- MAX_WAIT, 4, cycles requester 1 may be refused before it is force-granted (1..15).

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  synchronous reset, active-high.
- IssValid  in  1  an instruction is presented at issue this cycle.
- IssRs1  in  5  source register 1 of the issuing instruction.
- IssRs2  in  5  source register 2 of the issuing instruction.
- IssRd  in  5  destination register of the issuing instruction.
- IssLong  in  1  issuing instruction writes IssRd via requester 1.
- Stall  out  1  issue must hold this cycle (combinational).
- Valid0  in  1  requester 0 write request.
- Rd0  in  5  requester 0 destination.
- Data0  in  XLEN  requester 0 data.
- Ready0  out  1  requester 0 accepted this cycle (combinational).
- Valid1  in  1  requester 1 write request.
- Rd1  in  5  requester 1 destination.
- Data1  in  XLEN  requester 1 data.
- Ready1  out  1  requester 1 accepted this cycle (combinational).
- RegWEn  out  1  register file write enable (registered).
- AddrD  out  5  register file write address (registered).
- DataD  out  XLEN  register file write data (registered).
- Pending  out  32  scoreboard bit vector; bit 0 is always 0.

Behaviour:
- Reset (RST high at an edge):
  - RegWEn=0, AddrD=0, DataD=0, Pending=0, WaitCnt=0.
  - While RST is high: Ready0=0, Ready1=0, Stall=1.
  - Reset mid-operation discards any accepted-but-uncommitted write and all pending bits.
- Arbitration (combinational, RST low). Force = (WaitCnt==MAX_WAIT).
  - Ready1 = Valid1 & (!Valid0 | Force).
  - Ready0 = !(Valid1 & Force).
  - Ready0 may be 1 with Valid0=0.
  - A requester's handshake completes when Valid & Ready are both high.
- Requester 1 rules:
  - Must hold Valid1/Rd1/Data1 stable until accepted.
  - Requester 0 must hold its request while Ready0=0.
- WaitCnt:
  - Increments when Valid1 & !Ready1, saturating at MAX_WAIT.
  - Clears to 0 when Valid1 & Ready1, or when Valid1=0.
- Write stage, one-cycle latency:
  - A handshake in cycle N produces, in cycle N+1, RegWEn=1, AddrD=Rd, DataD=Data.
  - The register file commits at the edge ending N+1.
  - Cycles with no handshake give RegWEn=0; AddrD/DataD hold their previous values.
  - Rd==0: handshake completes but RegWEn stays 0.
- Scoreboard:
  - Set: Pending[IssRd] sets at the edge ending a cycle with IssValid & IssLong & !Stall & IssRd!=0.
  - Clear: Pending[r] clears at the same edge at which the requester-1 write to r commits (edge ending N+1). A requester-0 commit never clears a pending bit.
  - Set and clear on the same bit in the same cycle cannot occur, because of WAW stall.
- Stall = IssValid & (Pending[IssRs1] | Pending[IssRs2] | Pending[IssRd]). Indexing with register 0 never stalls.
- No bypass. A dependent instruction issues the cycle after the clear edge; it then reads the committed value from the combinational read ports.
- Requester 0 writing a pending register is an upstream error. Writes pass through unchanged and Pending is unaffected.

Test Plan:
- Reset: RST high 2 cycles during traffic -> RegWEn=0, AddrD=0, DataD=0, Pending=0, Ready0=Ready1=0, Stall=1. First cycle after: Stall=0 with IssValid=0.
- Back-to-back requester 0 only:
  - Valid0=1 for 3 cycles with Rd0=5,6,7 and Data0=0x11,0x22,0x33 -> RegWEn=1 on cycles 1..3 with AddrD/DataD matching, one cycle later each.
  - Rd0=0 -> RegWEn=0.
- Starvation, MAX_WAIT=4: Valid0 held 1 continuously; Valid1=1 with Rd1=9, Data1=0xDEAD from cycle 0.
  - Ready1=0 for cycles 0..3; Ready1=1 and Ready0=0 in cycle 4.
  - Cycle 5: RegWEn=1, AddrD=9, DataD=0xDEAD.
  - WaitCnt returns to 0.
- Scoreboard RAW:
  - Issue long op with IssRd=3 -> Pending[3]=1.
  - Next issue with IssRs2=3 -> Stall=1 until requester 1 writes 3.
  - Pending[3]=0 the cycle after RegWEn=1/AddrD=3; Stall drops that cycle.
- WAW and x0:
  - Long op with IssRd=3 pending; issue with IssRd=3 -> Stall=1.
  - Long issue with IssRd=0 -> Pending unchanged; Stall=0.
- Idle requester 1: Valid0=0, Valid1=1 -> Ready1=1 same cycle; write appears next cycle.

Source files
------------

// File: rtl/rf_wb_scheduler.sv
// rf_wb_scheduler: arbitrates the single register-file write port between
// the single-cycle pipeline (requester 0) and a multi-cycle mul/div unit
// (requester 1). It also keeps a scoreboard of destinations that have a
// long-latency write outstanding, and stalls issue on RAW/WAW hazards.
//
// Ports:
//   CLK, RST                 clock, synchronous active-high reset
//   IssValid/IssRs1/IssRs2/IssRd/IssLong   instruction at issue
//   Stall                    issue must hold (combinational)
//   Valid0/Rd0/Data0/Ready0  requester 0 (ALU/load) write handshake
//   Valid1/Rd1/Data1/Ready1  requester 1 (mul/div) write handshake
//   RegWEn/AddrD/DataD       registered register-file write port
//   Pending                  scoreboard, bit 0 always 0
module rf_wb_scheduler #(
  parameter int XLEN     = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            IssValid,
  input  logic [4:0]      IssRs1,
  input  logic [4:0]      IssRs2,
  input  logic [4:0]      IssRd,
  input  logic            IssLong,
  output logic            Stall,
  input  logic            Valid0,
  input  logic [4:0]      Rd0,
  input  logic [XLEN-1:0] Data0,
  output logic            Ready0,
  input  logic            Valid1,
  input  logic [4:0]      Rd1,
  input  logic [XLEN-1:0] Data1,
  output logic            Ready1,
  output logic            RegWEn,
  output logic [4:0]      AddrD,
  output logic [XLEN-1:0] DataD,
  output logic [31:0]     Pending
);

  logic [3:0]      wait_q, wait_d;
  logic [31:0]     pend_q, pend_d;
  logic            wen_q, wen_d;
  logic            src1_q, src1_d;   // committing write came from requester 1
  logic [4:0]      addr_q, addr_d;
  logic [XLEN-1:0] data_q, data_d;

  logic frc, hs0, hs1, issue_long;

  always_comb begin
    // Requester 1 is force-granted once it has been refused MAX_WAIT times.
    frc    = (wait_q == 4'(MAX_WAIT));
    Ready1 = !RST && Valid1 && (!Valid0 || frc);
    Ready0 = !RST && !(Valid1 && frc);
    hs0    = Valid0 && Ready0;
    hs1    = Valid1 && Ready1;

    // pend_q[0] is held at 0, so register 0 never contributes a hazard.
    Stall  = RST || (IssValid &&
             (pend_q[IssRs1] || pend_q[IssRs2] || pend_q[IssRd]));

    if (Valid1 && !Ready1) wait_d = frc ? wait_q : wait_q + 4'd1;
    else                   wait_d = 4'd0;

    // The two grants are mutually exclusive; address/data hold when idle.
    wen_d  = 1'b0;
    src1_d = 1'b0;
    addr_d = addr_q;
    data_d = data_q;
    if (hs1) begin
      wen_d  = (Rd1 != 5'd0);
      src1_d = 1'b1;
      addr_d = Rd1;
      data_d = Data1;
    end else if (hs0) begin
      wen_d  = (Rd0 != 5'd0);
      addr_d = Rd0;
      data_d = Data0;
    end

    // Clear on the edge the requester-1 write commits; WAW stall keeps a
    // set and a clear from ever targeting the same bit in one cycle.
    issue_long = IssValid && IssLong && !Stall && (IssRd != 5'd0);
    pend_d = pend_q;
    if (wen_q && src1_q) pend_d[addr_q] = 1'b0;
    if (issue_long)      pend_d[IssRd]  = 1'b1;
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wait_q <= 4'd0;
      pend_q <= 32'd0;
      wen_q  <= 1'b0;
      src1_q <= 1'b0;
      addr_q <= 5'd0;
      data_q <= '0;
    end else begin
      wait_q <= wait_d;
      pend_q <= pend_d;
      wen_q  <= wen_d;
      src1_q <= src1_d;
      addr_q <= addr_d;
      data_q <= data_d;
    end
  end

  assign RegWEn  = wen_q;
  assign AddrD   = addr_q;
  assign DataD   = data_q;
  assign Pending = pend_q;

endmodule
